diary_rtc: RTL and testbench
============================

Name: diary_rtc

Overview:
- Memory-mapped real-time-clock peripheral for the digital diary SoC.
- Bus responder on the CPU data bus in the peripheral-3 window, selected when daddr[19:16]==BASE_NIBBLE.
- Keeps time of day and calendar date, compares time against a programmable alarm, and raises a level interrupt.
- Reads are zero-latency combinational; writes commit on the rising clock edge.

Parameters:
BASE_NIBBLE, 4'h1, value of daddr[19:16] that selects this block
TICK_DIV, 50000000, clk cycles per one-second tick (must be >=2); benches use 4

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
daddr  input  32  byte address from CPU bus
dwdata  input  32  write data
dwe  input  4  per-byte write enables; lane i covers dwdata[8i+7:8i]
drdata  output  32  read data (combinational)
irq  output  1  alarm interrupt, level = STATUS.alarm_flag & CTRL.alarm_en
tick_1hz  output  1  one-cycle pulse on each seconds increment

Behaviour:
- Decode:
  - sel = (daddr[19:16]==BASE_NIBBLE).
  - Register index = daddr[4:2]; daddr[1:0] are ignored.
  - A write occurs when sel is high and dwe!=0. Only lanes whose dwe bit is set are updated.
- Register map (unlisted bits read 0 and ignore writes):
  - 0x00 CTRL: [0] run, [1] alarm_en.
  - 0x04 TIME: [5:0] sec, [13:8] min, [20:16] hour.
  - 0x08 DATE: [4:0] day, [11:8] month, [27:16] year.
  - 0x0C ALARM: same layout as TIME.
  - 0x10 STATUS: [0] alarm_flag, write-1-to-clear.
  - 0x14 PRESC: [31:0] current prescaler count, read-only.
  - Indices 6-7 read 0 and ignore writes.
- drdata:
  - Returns the selected register when sel is high; 0 when sel is low.
  - A read in the same cycle as a write returns the pre-write value.
- Reset values: CTRL=0, TIME=0 (00:00:00), DATE day=1 month=1 year=0, ALARM=0, alarm_flag=0, prescaler=0, irq=0, tick_1hz=0.
- Prescaler (32-bit):
  - When run=1, increments every cycle.
  - On reaching TICK_DIV-1 it wraps to 0, and the seconds increment plus tick_1hz fire in that cycle's update (visible next cycle).
  - When run=0 it holds its value with no ticks; it resumes from the held value when run returns to 1.
- Increment chain, applied on tick:
  - sec>=59 -> 0 and carry, else sec+1.
  - min>=59 -> 0 and carry.
  - hour>=23 -> 0 and carry.
  - day>=dim(month,year) -> 1 and carry.
  - month>=12 -> 1 and carry.
  - year is 12-bit and wraps 4095 -> 0.
  - The ">=" comparisons mean out-of-range software-written values roll over on the next tick.
- Days in month (dim): 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February per the optional feature; month values 0 or 13-15 are treated as 31 days.
- Write vs tick in the same cycle:
  - A write to TIME or DATE wins; that field group takes the written value and the tick's carry into it is discarded.
  - Any TIME write also clears the prescaler to 0, so a full second elapses before the next tick.
  - tick_1hz still pulses.
- Alarm:
  - Compared only in cycles where a tick updates TIME.
  - If the new {hour,min,sec} equals ALARM, alarm_flag sets, regardless of alarm_en.
  - Software writes to TIME never set the flag.
- STATUS clear:
  - Writing 1 to bit0 with dwe[0]=1 clears alarm_flag.
  - If a set and a clear occur in the same cycle, set wins.
- irq and tick_1hz are registered outputs.
- Reset asserted mid-operation returns all state to reset values on that edge.

Optional Feature:
- Macro: DIARY_RTC_LEAP_EN.
- Defined: February has 29 days when year[1:0]==0, otherwise 28.
- Undefined: February always has 28 days; year does not affect dim.

Test Plan:
- Reset, then read every index with daddr=0x0001_0000+4*i -> CTRL=0, TIME=0, DATE=0x0000_0101, ALARM=0, STATUS=0, PRESC=0; any address with daddr[19:16]!=1 reads 0.
- TICK_DIV=4, write TIME=0x0017_3B3B (23:59:59), DATE=0x07E7_0C1F (31 Dec 2023), CTRL=1; wait 4 cycles -> TIME=0, DATE=0x07E8_0101, exactly one tick_1hz pulse.
- Leap year: DATE=0x07E8_021C (28 Feb 2024), TIME=23:59:59, run -> with DIARY_RTC_LEAP_EN DATE=0x07E8_021D; without the macro DATE=0x07E8_0301.
- ALARM=0x0000_0005, alarm_en=1, TIME=0, run 5 ticks -> alarm_flag=1 and irq=1 one cycle after the 5th tick; write STATUS=1 -> irq=0. Repeat with alarm_en=0 -> flag=1, irq stays 0.
- Byte enables: write 0xFFFF_FF2A to TIME with dwe=4'b0001 -> sec=42, min and hour unchanged. Write TIME in the exact tick cycle -> written value held, prescaler reads 0.
- Run stop: run=1 for 2 cycles, then run=0 for 10 cycles -> PRESC holds at 2 with no ticks; run=1 -> tick occurs after 2 further cycles.

Source files
------------

// File: rtl/diary_rtc.sv
// Memory-mapped RTC: time of day, calendar date, alarm compare and level interrupt.
// Define DIARY_RTC_LEAP_EN to give February 29 days in years with year[1:0]==0.
module diary_rtc #(
  parameter logic [3:0]  BASE_NIBBLE = 4'h1,
  parameter int unsigned TICK_DIV    = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        irq,
  output logic        tick_1hz
);

  localparam logic [31:0] PRESC_TOP = 32'(TICK_DIV - 1);

  logic        run_q, run_d, alarm_en_q, alarm_en_d;
  logic [5:0]  sec_q, sec_d, min_q, min_d;
  logic [4:0]  hour_q, hour_d;
  logic [4:0]  day_q, day_d;
  logic [3:0]  month_q, month_d;
  logic [11:0] year_q, year_d;
  logic [5:0]  al_sec_q, al_sec_d, al_min_q, al_min_d;
  logic [4:0]  al_hour_q, al_hour_d;
  logic        flag_q, flag_d;
  logic [31:0] presc_q, presc_d;
  logic        irq_q, irq_d, tick_q, tick_d;

  logic        sel, we, wr_ctrl, wr_time, wr_date, wr_alarm, wr_status;
  logic [2:0]  idx;
  logic        tick, feb_leap;
  logic [5:0]  t_sec, t_min;
  logic [4:0]  t_hour, t_day;
  logic [3:0]  t_month;
  logic [11:0] t_year;
  logic        c_min, c_hour, c_day, c_month, c_year;
  logic        alarm_set, alarm_clr;
  logic        unused_bits;

  assign sel       = (daddr[19:16] == BASE_NIBBLE);
  assign idx       = daddr[4:2];
  assign we        = sel && (dwe != 4'b0000);
  assign wr_ctrl   = we && (idx == 3'd0);
  assign wr_time   = we && (idx == 3'd1);
  assign wr_date   = we && (idx == 3'd2);
  assign wr_alarm  = we && (idx == 3'd3);
  assign wr_status = we && (idx == 3'd4);
  assign tick      = run_q && (presc_q == PRESC_TOP);

  assign unused_bits = ^{daddr[31:20], daddr[15:5], daddr[1:0],
                         dwdata[31:28], dwdata[15:14], dwdata[7:6]};

`ifdef DIARY_RTC_LEAP_EN
  assign feb_leap = (year_q[1:0] == 2'b00);
`else
  assign feb_leap = 1'b0;
`endif

  function automatic logic [4:0] dim(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                    dim = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
  endfunction

  // Tick increment chain, evaluated on current values; ">=" lets bad values roll over.
  always_comb begin
    t_sec = sec_q; t_min = min_q; t_hour = hour_q;
    t_day = day_q; t_month = month_q; t_year = year_q;
    c_min = 1'b0; c_hour = 1'b0; c_day = 1'b0; c_month = 1'b0; c_year = 1'b0;
    if (sec_q >= 6'd59) begin t_sec = 6'd0; c_min = 1'b1; end
    else t_sec = sec_q + 6'd1;
    if (c_min) begin
      if (min_q >= 6'd59) begin t_min = 6'd0; c_hour = 1'b1; end
      else t_min = min_q + 6'd1;
    end
    if (c_hour) begin
      if (hour_q >= 5'd23) begin t_hour = 5'd0; c_day = 1'b1; end
      else t_hour = hour_q + 5'd1;
    end
    if (c_day) begin
      if (day_q >= dim(month_q, feb_leap)) begin t_day = 5'd1; c_month = 1'b1; end
      else t_day = day_q + 5'd1;
    end
    if (c_month) begin
      if (month_q >= 4'd12) begin t_month = 4'd1; c_year = 1'b1; end
      else t_month = month_q + 4'd1;
    end
    if (c_year) t_year = year_q + 12'd1;
  end

  always_comb begin
    run_d = run_q; alarm_en_d = alarm_en_q;
    sec_d = sec_q; min_d = min_q; hour_d = hour_q;
    day_d = day_q; month_d = month_q; year_d = year_q;
    al_sec_d = al_sec_q; al_min_d = al_min_q; al_hour_d = al_hour_q;
    presc_d = presc_q;
    if (run_q) presc_d = tick ? 32'd0 : presc_q + 32'd1;
    if (tick) begin
      sec_d = t_sec; min_d = t_min; hour_d = t_hour;
      day_d = t_day; month_d = t_month; year_d = t_year;
    end
    // A software write owns its whole field group; unwritten lanes keep the pre-tick value.
    if (wr_time) begin
      sec_d   = dwe[0] ? dwdata[5:0]   : sec_q;
      min_d   = dwe[1] ? dwdata[13:8]  : min_q;
      hour_d  = dwe[2] ? dwdata[20:16] : hour_q;
      presc_d = 32'd0;
    end
    if (wr_date) begin
      day_d         = dwe[0] ? dwdata[4:0]   : day_q;
      month_d       = dwe[1] ? dwdata[11:8]  : month_q;
      year_d[7:0]   = dwe[2] ? dwdata[23:16] : year_q[7:0];
      year_d[11:8]  = dwe[3] ? dwdata[27:24] : year_q[11:8];
    end
    if (wr_ctrl && dwe[0]) begin
      run_d      = dwdata[0];
      alarm_en_d = dwdata[1];
    end
    if (wr_alarm) begin
      if (dwe[0]) al_sec_d  = dwdata[5:0];
      if (dwe[1]) al_min_d  = dwdata[13:8];
      if (dwe[2]) al_hour_d = dwdata[20:16];
    end
    alarm_set = tick && !wr_time &&
                ({t_hour, t_min, t_sec} == {al_hour_q, al_min_q, al_sec_q});
    alarm_clr = wr_status && dwe[0] && dwdata[0];
    flag_d    = alarm_set || (flag_q && !alarm_clr);
    irq_d     = flag_d && alarm_en_d;
    tick_d    = tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0; alarm_en_q <= 1'b0;
      sec_q <= '0; min_q <= '0; hour_q <= '0;
      day_q <= 5'd1; month_q <= 4'd1; year_q <= '0;
      al_sec_q <= '0; al_min_q <= '0; al_hour_q <= '0;
      flag_q <= 1'b0; presc_q <= '0; irq_q <= 1'b0; tick_q <= 1'b0;
    end else begin
      run_q <= run_d; alarm_en_q <= alarm_en_d;
      sec_q <= sec_d; min_q <= min_d; hour_q <= hour_d;
      day_q <= day_d; month_q <= month_d; year_q <= year_d;
      al_sec_q <= al_sec_d; al_min_q <= al_min_d; al_hour_q <= al_hour_d;
      flag_q <= flag_d; presc_q <= presc_d; irq_q <= irq_d; tick_q <= tick_d;
    end
  end

  always_comb begin
    drdata = 32'd0;
    if (sel) begin
      case (idx)
        3'd0: drdata = {30'd0, alarm_en_q, run_q};
        3'd1: drdata = {11'd0, hour_q, 2'd0, min_q, 2'd0, sec_q};
        3'd2: drdata = {4'd0, year_q, 4'd0, month_q, 3'd0, day_q};
        3'd3: drdata = {11'd0, al_hour_q, 2'd0, al_min_q, 2'd0, al_sec_q};
        3'd4: drdata = {31'd0, flag_q};
        3'd5: drdata = presc_q;
        default: drdata = 32'd0;
      endcase
    end
  end

  assign irq      = irq_q;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_diary_rtc.sv
// Directed and randomized checks of diary_rtc against a calendar-arithmetic model.
module tb_diary_rtc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dwe;
  logic        irq, tick_1hz;

  int n_pass = 0;
  int n_total = 0;

  diary_rtc #(.BASE_NIBBLE(4'h1), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .irq(irq), .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  // Reference model: time as seconds-of-day, date as day/month/year.
  int m_sod, m_day, m_mon, m_year, m_al_sod;
  bit m_flag;

  function automatic int days_in(input int mon, input int yr);
    case (mon)
`ifdef DIARY_RTC_LEAP_EN
      2: days_in = (yr % 4 == 0) ? 29 : 28;
`else
      2: days_in = 28;
`endif
      4, 6, 9, 11: days_in = 30;
      default: days_in = 31;
    endcase
  endfunction

  function automatic logic [31:0] pack_time(input int sod);
    pack_time = 32'((sod / 3600) * 65536 + ((sod / 60) % 60) * 256 + sod % 60);
  endfunction

  function automatic logic [31:0] pack_date(input int d, input int mo, input int y);
    pack_date = 32'(y * 65536 + mo * 256 + d);
  endfunction

  task automatic model_tick();
    m_sod = m_sod + 1;
    if (m_sod == 86400) begin
      m_sod = 0;
      if (m_day >= days_in(m_mon, m_year)) begin
        m_day = 1;
        if (m_mon == 12) begin m_mon = 1; m_year = (m_year + 1) % 4096; end
        else m_mon = m_mon + 1;
      end else m_day = m_day + 1;
    end
    if (m_sod == m_al_sod) m_flag = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] be);
    daddr  = 32'h0001_0000 + 32'(4 * idx);
    dwdata = d;
    dwe    = be;
    @(posedge clk); #1;
    dwe   = 4'b0000;
    daddr = 32'h0;
  endtask

  task automatic rd(input int idx, output logic [31:0] v);
    daddr = 32'h0001_0000 + 32'(4 * idx);
    dwe   = 4'b0000;
    #1;
    v = drdata;
  endtask

  task automatic run_cycles(input int n, output int ticks);
    ticks = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (tick_1hz) ticks++;
    end
  endtask

  logic [31:0] v;
  int          tk;
  logic [31:0] exp_reset [6] = '{32'h0, 32'h0, 32'h0000_0101, 32'h0, 32'h0, 32'h0};

  initial begin
    reset = 1'b1; daddr = '0; dwdata = '0; dwe = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      chk($sformatf("reset_idx%0d", i), v, (i < 6) ? exp_reset[i] : 32'h0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_tick", {31'd0, tick_1hz}, 32'd0);
    daddr = 32'h0002_0008; #1;
    chk("unselected_read", drdata, 32'h0);

    // Byte-lane write to TIME.
    wr(1, 32'h0005_0607, 4'b1111);
    wr(1, 32'hFFFF_FF2A, 4'b0001);
    rd(1, v); chk("byte_lane_time", v, 32'h0005_062A);

    // Out-of-range seconds roll over on the next tick.
    wr(1, 32'h0000_003C, 4'b1111);
    wr(0, 32'h1, 4'b0001);
    run_cycles(4, tk);
    rd(1, v); chk("out_of_range_sec", v, 32'h0000_0100);

    // Year-end rollover.
    wr(0, 32'h0, 4'b0001);
    wr(1, 32'h0017_3B3B, 4'b1111);
    wr(2, 32'h07E7_0C1F, 4'b1111);
    wr(0, 32'h1, 4'b0001);
    run_cycles(4, tk);
    rd(1, v); chk("rollover_time", v, 32'h0);
    rd(2, v); chk("rollover_date", v, 32'h07E8_0101);
    chk("rollover_ticks", 32'(tk), 32'd1);

    // End of February 2024.
    wr(0, 32'h0, 4'b0001);
    wr(1, 32'h0017_3B3B, 4'b1111);
    wr(2, 32'h07E8_021C, 4'b1111);
    wr(0, 32'h1, 4'b0001);
    run_cycles(4, tk);
    rd(2, v);
`ifdef DIARY_RTC_LEAP_EN
    chk("feb_2024", v, 32'h07E8_021D);
`else
    chk("feb_2024", v, 32'h07E8_0301);
`endif

    // Alarm with interrupt enabled.
    wr(0, 32'h0, 4'b0001);
    wr(3, 32'h0000_0005, 4'b1111);
    wr(4, 32'h1, 4'b0001);
    wr(1, 32'h0, 4'b1111);
    wr(0, 32'h3, 4'b0001);
    run_cycles(19, tk);
    rd(4, v); chk("alarm_not_yet", v, 32'h0);
    chk("irq_not_yet", {31'd0, irq}, 32'd0);
    run_cycles(1, tk);
    rd(4, v); chk("alarm_flag_set", v, 32'h1);
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(4, 32'h1, 4'b0001);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // Alarm with interrupt disabled; wrong lane must not clear.
    wr(0, 32'h0, 4'b0001);
    wr(1, 32'h0, 4'b1111);
    wr(0, 32'h1, 4'b0001);
    run_cycles(20, tk);
    rd(4, v); chk("alarm_flag_no_en", v, 32'h1);
    chk("irq_no_en", {31'd0, irq}, 32'd0);
    wr(4, 32'h0000_0101, 4'b0010);
    rd(4, v); chk("status_wrong_lane", v, 32'h1);
    wr(4, 32'h1, 4'b0001);
    rd(4, v); chk("status_clear", v, 32'h0);
    wr(0, 32'h0, 4'b0001);

    // TIME written in the exact tick cycle.
    wr(1, 32'h0000_0000, 4'b1111);
    wr(0, 32'h1, 4'b0001);
    run_cycles(3, tk);
    wr(1, 32'h0001_0203, 4'b0111);
    chk("tick_cycle_pulse", {31'd0, tick_1hz}, 32'd1);
    rd(1, v); chk("tick_cycle_time", v, 32'h0001_0203);
    rd(5, v); chk("tick_cycle_presc", v, 32'h0);

    // Stop and resume the prescaler.
    wr(0, 32'h0, 4'b0001);
    wr(1, 32'h0, 4'b1111);
    wr(0, 32'h1, 4'b0001);
    run_cycles(1, tk);
    wr(0, 32'h0, 4'b0001);
    run_cycles(10, tk);
    rd(5, v); chk("stop_presc_hold", v, 32'd2);
    chk("stop_no_ticks", 32'(tk), 32'd0);
    wr(0, 32'h1, 4'b0001);
    run_cycles(1, tk);
    chk("resume_no_tick_yet", 32'(tk), 32'd0);
    run_cycles(1, tk);
    chk("resume_tick", 32'(tk), 32'd1);

    // Randomized boundary-heavy runs against the model.
    for (int it = 0; it < 20; it++) begin
      int hr, mn, sc, k;
      bit en;
      wr(0, 32'h0, 4'b0001);
      wr(4, 32'h1, 4'b0001);
      hr = $urandom_range(22, 23); mn = $urandom_range(58, 59); sc = $urandom_range(55, 59);
      m_mon = $urandom_range(1, 12); m_year = $urandom_range(0, 4095);
      if ($urandom_range(0, 3) == 0) begin m_mon = 12; m_year = 4095; end
      m_day = days_in(m_mon, m_year) - $urandom_range(0, 1);
      m_sod = hr * 3600 + mn * 60 + sc;
      m_al_sod = (m_sod + $urandom_range(1, 6)) % 86400;
      m_flag = 1'b0;
      en = 1'($urandom_range(0, 1));
      wr(3, pack_time(m_al_sod), 4'b1111);
      wr(1, pack_time(m_sod), 4'b1111);
      wr(2, pack_date(m_day, m_mon, m_year), 4'b1111);
      wr(0, {30'd0, en, 1'b1}, 4'b0001);
      k = $urandom_range(1, 5);
      run_cycles(4 * k, tk);
      for (int j = 0; j < k; j++) model_tick();
      rd(1, v); chk($sformatf("rand%0d_time", it), v, pack_time(m_sod));
      rd(2, v); chk($sformatf("rand%0d_date", it), v, pack_date(m_day, m_mon, m_year));
      chk($sformatf("rand%0d_ticks", it), 32'(tk), 32'(k));
      rd(4, v); chk($sformatf("rand%0d_flag", it), v, {31'd0, m_flag});
      chk($sformatf("rand%0d_irq", it), {31'd0, irq}, {31'd0, m_flag & en});
    end

    // Reset in the middle of a run.
    wr(1, 32'h0003_0405, 4'b1111);
    wr(0, 32'h3, 4'b0001);
    run_cycles(2, tk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd(0, v); chk("midreset_ctrl", v, 32'h0);
    rd(1, v); chk("midreset_time", v, 32'h0);
    rd(2, v); chk("midreset_date", v, 32'h0000_0101);
    rd(5, v); chk("midreset_presc", v, 32'h0);
    chk("midreset_irq", {31'd0, irq}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
